// File: rtl/tt_sweep_driver_pkg.sv
// Shared types and sizing helpers for the truth-table sweep driver (package tt_pkg).
// The optional per-output ones counter is enabled with TT_SWEEP_ONES_CNT_EN.
package tt_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } tt_state_e;

   function automatic int tt_depth(input int n_in);
      return 2 ** n_in;
   endfunction

   // SETTLE-1 must fit in the counter; SETTLE is at least 1.
   function automatic int tt_cnt_w(input int settle);
      return (settle < 2) ? 1 : $clog2(settle + 1);
   endfunction

endpackage

// File: rtl/tt_sweep_driver_if.sv
// Stimulus/response and control bundle between a sweep requester and tt_sweep_driver.
// The ones_cnt member exists only when TT_SWEEP_ONES_CNT_EN is defined.
interface tt_sweep_if
   import tt_pkg::*;
#(
   parameter int N_IN  = 3,
   parameter int N_OUT = 2
);
   logic                              start;
   logic [N_IN-1:0]                   stim;
   logic [N_OUT-1:0]                  resp;
   logic                              busy;
   logic                              done;
   logic [N_IN-1:0]                   idx;
   logic [N_OUT*tt_depth(N_IN)-1:0]   table_out;
`ifdef TT_SWEEP_ONES_CNT_EN
   logic [N_OUT*(N_IN+1)-1:0]         ones_cnt;

   modport master (output start, resp, input stim, busy, done, idx, table_out, ones_cnt);
   modport slave  (input start, resp, output stim, busy, done, idx, table_out, ones_cnt);
`else
   modport master (output start, resp, input stim, busy, done, idx, table_out);
   modport slave  (input start, resp, output stim, busy, done, idx, table_out);
`endif
endinterface

// File: rtl/tt_sweep_driver_settle_timer.sv
// Loadable down-counter with a zero flag; paces the settle interval of each combination.
module tt_settle_timer #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);
   logic [W-1:0] cnt_q, cnt_d;

   // next count: load has priority, decrement saturates at zero
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != {W{1'b0}})) begin
         cnt_d = cnt_q - W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // count register
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= {W{1'b0}};
      else     cnt_q <= cnt_d;
   end

   assign zero = (cnt_q == {W{1'b0}});
endmodule

// File: rtl/tt_sweep_driver.sv
// Clocked truth-table sweep: steps stim through every input code, samples resp after settling.
// Optional per-output ones counter under TT_SWEEP_ONES_CNT_EN.
module tt_sweep_driver
   import tt_pkg::*;
#(
   parameter int N_IN   = 3,
   parameter int N_OUT  = 2,
   parameter int SETTLE = 1
) (
   input  logic       clk,
   input  logic       rst,
   tt_sweep_if.slave  bus
);
   localparam int              DEPTH    = tt_depth(N_IN);
   localparam int              CNT_W    = tt_cnt_w(SETTLE);
   localparam int              TBL_W    = N_OUT * DEPTH;
   localparam logic [CNT_W-1:0] RELOAD  = CNT_W'(SETTLE - 1);
   localparam logic [N_IN-1:0]  IDX_LAST = N_IN'(DEPTH - 1);

   tt_state_e         state_q, state_d;
   logic [N_IN-1:0]   idx_q, idx_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [TBL_W-1:0]  table_q, table_d;
   logic              tmr_load_s, tmr_dec_s, tmr_zero_s;
`ifdef TT_SWEEP_ONES_CNT_EN
   logic [N_OUT*(N_IN+1)-1:0] ones_q, ones_d;
`endif

   tt_settle_timer #(.W(CNT_W)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load_s),
      .load_val (RELOAD),
      .dec      (tmr_dec_s),
      .zero     (tmr_zero_s)
   );

   // sweep sequencing and table capture
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      table_d    = table_q;
      tmr_load_s = 1'b0;
      tmr_dec_s  = 1'b0;
`ifdef TT_SWEEP_ONES_CNT_EN
      ones_d     = ones_q;
`endif
      case (state_q)
         ST_IDLE: begin
            // done_q high means this is the done cycle, where start is not honoured
            if (bus.start && !done_q) begin
               state_d    = ST_SETTLE;
               idx_d      = {N_IN{1'b0}};
               busy_d     = 1'b1;
               table_d    = {TBL_W{1'b0}};
               tmr_load_s = 1'b1;
`ifdef TT_SWEEP_ONES_CNT_EN
               ones_d     = {(N_OUT*(N_IN+1)){1'b0}};
`endif
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SETTLE: begin
            if (tmr_zero_s) state_d = ST_SAMPLE;
            else            tmr_dec_s = 1'b1;
         end
         ST_SAMPLE: begin
            for (int o = 0; o < N_OUT; o++) begin
               for (int i = 0; i < DEPTH; i++) begin
                  if (idx_q == i[N_IN-1:0]) table_d[o*DEPTH+i] = bus.resp[o];
                  else                      table_d[o*DEPTH+i] = table_q[o*DEPTH+i];
               end
`ifdef TT_SWEEP_ONES_CNT_EN
               ones_d[o*(N_IN+1) +: (N_IN+1)] =
                  ones_q[o*(N_IN+1) +: (N_IN+1)] + (N_IN+1)'(bus.resp[o]);
`endif
            end
            // terminal compare wins so idx never wraps inside a sweep
            if (idx_q == IDX_LAST) begin
               state_d = ST_DONE;
            end else begin
               idx_d      = idx_q + N_IN'(1);
               tmr_load_s = 1'b1;
               state_d    = ST_SETTLE;
            end
         end
         ST_DONE: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // state and registered outputs; reset aborts any sweep in progress
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= {N_IN{1'b0}};
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         table_q <= {TBL_W{1'b0}};
`ifdef TT_SWEEP_ONES_CNT_EN
         ones_q  <= {(N_OUT*(N_IN+1)){1'b0}};
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         table_q <= table_d;
`ifdef TT_SWEEP_ONES_CNT_EN
         ones_q  <= ones_d;
`endif
      end
   end

   assign bus.stim      = idx_q;
   assign bus.idx       = idx_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.table_out = table_q;
`ifdef TT_SWEEP_ONES_CNT_EN
   assign bus.ones_cnt  = ones_q;
`endif
endmodule

// File: tb/tb_tt_sweep_driver.sv
// Self-checking bench for tt_sweep_driver: table-driven sweeps plus restart, reset and long-settle cases.
// Checks ones_cnt only when TT_SWEEP_ONES_CNT_EN is defined.
module tb_tt_sweep_driver;

   logic clk = 1'b0;
   logic rst;
   logic mode1;
   int   t3 = 0;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   tt_sweep_if #(.N_IN(3), .N_OUT(2)) bus1 ();
   tt_sweep_if #(.N_IN(3), .N_OUT(2)) bus3 ();

   tt_sweep_driver #(.N_IN(3), .N_OUT(2), .SETTLE(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
   tt_sweep_driver #(.N_IN(3), .N_OUT(2), .SETTLE(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

   function automatic logic fxyz(input logic [2:0] s);
      return s[2] | ~s[1];
   endfunction

   // mode1=0: fxyz on both outputs; mode1=1: parity stub on resp[0], resp[1]=0
   assign bus1.resp = mode1 ? {1'b0, ^bus1.stim} : {2{fxyz(bus1.stim)}};
   // long-settle DUT sees inverted (wrong) data everywhere except its SAMPLE cycle
   assign bus3.resp = ((t3 % 4) == 3) ? {2{fxyz(bus3.stim)}} : ~{2{fxyz(bus3.stim)}};

   // cycles since the last start seen by the long-settle DUT
   always @(posedge clk) t3 <= bus3.start ? 0 : t3 + 1;

   typedef struct {
      logic        mode;
      logic [15:0] table_exp;
      logic [7:0]  ones_exp;
      string       name;
   } vec_t;

   typedef struct {
      logic [15:0] table_exp;
      logic [7:0]  ones_exp;
      int          lat;
   } exp_t;

   exp_t sb_q[$];
   vec_t vecs[4];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic sweep1(input logic m, input logic [15:0] te, input logic [7:0] oe,
                         input int restart_at, input logic start_on_done, input string name);
      exp_t e;
      int   lat;
      int   seq_bad;
      int   exp_idx;
      mode1 = m;
      e = '{te, oe, 17};
      sb_q.push_back(e);
      bus1.start = 1'b1;
      @(negedge clk);
      bus1.start = 1'b0;
      check({name, "_busy_rise"}, bus1.busy, 1);
      lat = 0;
      seq_bad = 0;
      while (!bus1.done && lat < 200) begin
         exp_idx = (lat / 2 > 7) ? 7 : lat / 2;
         if (bus1.idx !== exp_idx[2:0] || bus1.stim !== exp_idx[2:0]) seq_bad++;
         bus1.start = (lat == restart_at);
         @(negedge clk);
         lat++;
      end
      bus1.start = start_on_done;
      e = sb_q.pop_front();
      check({name, "_done"}, bus1.done, 1);
      check({name, "_latency"}, lat, e.lat);
      check({name, "_stim_seq_errs"}, seq_bad, 0);
      check({name, "_table"}, bus1.table_out, e.table_exp);
      check({name, "_busy_at_done"}, bus1.busy, 0);
`ifdef TT_SWEEP_ONES_CNT_EN
      check({name, "_ones_cnt"}, bus1.ones_cnt, e.ones_exp);
`endif
      @(negedge clk);
      bus1.start = 1'b0;
      check({name, "_done_width"}, bus1.done, 0);
      check({name, "_busy_after"}, bus1.busy, 0);
      check({name, "_table_hold"}, bus1.table_out, e.table_exp);
      check({name, "_idx_hold"}, bus1.idx, 7);
   endtask

   initial begin
      int lat;
      int done_cnt;
      exp_t e;

      vecs[0] = '{1'b0, 16'hF3F3, 8'h66, "fxyz"};
      vecs[1] = '{1'b1, 16'h0096, 8'h04, "xor"};
      vecs[2] = '{1'b0, 16'hF3F3, 8'h66, "fxyz_again"};
      vecs[3] = '{1'b1, 16'h0096, 8'h04, "xor_again"};

      rst = 1'b1;
      mode1 = 1'b0;
      bus1.start = 1'b0;
      bus3.start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_busy", bus1.busy, 0);
      check("rst_done", bus1.done, 0);
      check("rst_idx", bus1.idx, 0);
      check("rst_stim", bus1.stim, 0);
      check("rst_table", bus1.table_out, 0);
      check("rst_busy3", bus3.busy, 0);
      check("rst_table3", bus3.table_out, 0);
`ifdef TT_SWEEP_ONES_CNT_EN
      check("rst_ones", bus1.ones_cnt, 0);
`endif
      @(negedge clk);

      for (int i = 0; i < 4; i++) begin
         sweep1(vecs[i].mode, vecs[i].table_exp, vecs[i].ones_exp, -1, 1'b0, vecs[i].name);
      end

      // second start mid-sweep must be ignored
      sweep1(1'b0, 16'hF3F3, 8'h66, 5, 1'b0, "restart");

      // start coincident with done must be ignored and not queued
      sweep1(1'b1, 16'h0096, 8'h04, -1, 1'b1, "start_on_done");
      repeat (3) @(negedge clk);
      check("start_on_done_not_queued", bus1.busy, 0);

      // reset in the middle of a sweep
      mode1 = 1'b0;
      bus1.start = 1'b1;
      @(negedge clk);
      bus1.start = 1'b0;
      for (int i = 0; i < 9; i++) @(negedge clk);
      check("pre_rst_table_nonzero", (bus1.table_out != 16'h0000), 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_busy", bus1.busy, 0);
      check("midrst_table", bus1.table_out, 0);
      check("midrst_idx", bus1.idx, 0);
      check("midrst_stim", bus1.stim, 0);
      done_cnt = 0;
      for (int i = 0; i < 25; i++) begin
         if (bus1.done) done_cnt++;
         @(negedge clk);
      end
      check("midrst_no_done", done_cnt, 0);
      check("midrst_stays_idle", bus1.busy, 0);
      sweep1(1'b0, 16'hF3F3, 8'h66, -1, 1'b0, "after_rst");

      // SETTLE=3 DUT with wrong resp outside its SAMPLE cycles
      e = '{16'hF3F3, 8'h66, 33};
      sb_q.push_back(e);
      bus3.start = 1'b1;
      @(negedge clk);
      bus3.start = 1'b0;
      check("s3_busy_rise", bus3.busy, 1);
      lat = 0;
      while (!bus3.done && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      e = sb_q.pop_front();
      check("s3_done", bus3.done, 1);
      check("s3_latency", lat, e.lat);
      check("s3_table", bus3.table_out, e.table_exp);
      check("s3_busy_at_done", bus3.busy, 0);
`ifdef TT_SWEEP_ONES_CNT_EN
      check("s3_ones_cnt", bus3.ones_cnt, e.ones_exp);
`endif
      @(negedge clk);
      check("s3_done_width", bus3.done, 0);
      check("s3_table_hold", bus3.table_out, e.table_exp);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
